// File: rtl/trig_stretch_pkg.sv
// ============================================================================
// Module      : trig_stretch_pkg
// Description : Shared types and helpers for the trigger stretch/scaler path:
//               channel FSM state encoding, read latency and the flat
//               channel-address helper (level*NBEAMS + beam).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trig_stretch_pkg;

  // Per-channel FSM state, explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STRETCH = 2'd1,
    HOLDOFF = 2'd2
  } trig_st_t;

  // Cycles from rd_en_i to rd_valid_o (address register + mux register)
  localparam int RD_LATENCY = 2;

  // Width of the scaler read data bus
  localparam int RD_DAT_W = 32;

  // Flat channel index used for both the read address and the hold array
  function automatic int chan_addr(input int level, input int beam, input int nbeams);
    return level * nbeams + beam;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trig_stretch_chan.sv
// ============================================================================
// Module      : trig_stretch_chan
// Description : One trigger channel: IDLE/STRETCH/HOLDOFF FSM with its
//               length counter, saturating scaler and end-of-period hold.
//               With TRIG_STRETCH_SATFLAG_EN defined, a per-channel flag
//               records whether the held period's counter saturated.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_stretch_chan
  import trig_stretch_pkg::*;
#(
  parameter int STRETCH_LEN = 4,
  parameter int HOLDOFF_LEN = 8,
  parameter int SCAL_BITS   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,       // unmasked rising edge seen this cycle
  input  logic                 timer_i,
  input  logic                 scal_rst_i,
  output logic                 trig_o,
  output logic [SCAL_BITS-1:0] hold_o,
  output logic                 sat_o
);

  localparam int LEN_MAX = (STRETCH_LEN > HOLDOFF_LEN) ? STRETCH_LEN : HOLDOFF_LEN;
  localparam int TMR_W   = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;

  // The timer holds "cycles remaining minus one" so a phase ends when it hits 0
  localparam logic [TMR_W-1:0]     STRETCH_LAST = TMR_W'(STRETCH_LEN - 1);
  localparam logic [TMR_W-1:0]     HOLDOFF_LAST = TMR_W'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);
  localparam logic [SCAL_BITS-1:0] CNT_MAX      = '1;

  trig_st_t             state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [SCAL_BITS-1:0] cnt_q, cnt_d;
  logic [SCAL_BITS-1:0] hold_q, hold_d;
  logic                 accept_w;

  // State, phase timer and scaler registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state: stretch for STRETCH_LEN cycles, then optional holdoff
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = STRETCH;
          tmr_d   = STRETCH_LAST;
        end
      end
      STRETCH: begin
        if (tmr_q == '0) begin
          if (HOLDOFF_LEN > 0) begin
            state_d = HOLDOFF;
            tmr_d   = HOLDOFF_LAST;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      HOLDOFF: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Outputs: an edge is only accepted from IDLE; trig_o follows STRETCH
  always_comb begin
    accept_w = (state_q == IDLE) && req_i;
    trig_o   = (state_q == STRETCH);
  end

  // Scaler: clear wins, timer banks the count and starts a new period
  // (an acceptance in the same cycle counts into the new period)
  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (scal_rst_i) begin
      cnt_d  = '0;
      hold_d = '0;
    end else if (timer_i) begin
      hold_d = cnt_q;
      cnt_d  = accept_w ? SCAL_BITS'(1) : '0;
    end else if (accept_w && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + SCAL_BITS'(1);
    end
  end

  assign hold_o = hold_q;

`ifdef TRIG_STRETCH_SATFLAG_EN
  // A saturated counter sticks at max, so its value at banking time is enough
  logic sat_q, sat_d;

  // Saturation flag follows the hold register's banking and clearing
  always_comb begin
    sat_d = sat_q;
    if (scal_rst_i) begin
      sat_d = 1'b0;
    end else if (timer_i) begin
      sat_d = (cnt_q == CNT_MAX);
    end
  end

  // Saturation flag register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;
`else
  assign sat_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/trig_stretch_scaler.sv
// ============================================================================
// Module      : trig_stretch_scaler
// Description : Per-beam, per-level trigger stretcher with holdoff, masking
//               and timer-banked scalers read through a 2-stage pipelined
//               mux. Top-level holds edge detect, mask fan-out, bank/done
//               logic and the read path; channels are trig_stretch_chan.
//               Optional macro TRIG_STRETCH_SATFLAG_EN places a per-channel
//               saturation flag on rd_dat_o[31].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_stretch_scaler
  import trig_stretch_pkg::*;
#(
  parameter  int NBEAMS      = 54,
  parameter  int NLEVELS     = 2,
  parameter  int STRETCH_LEN = 4,
  parameter  int HOLDOFF_LEN = 8,
  parameter  int SCAL_BITS   = 16,
  localparam int NCHAN       = NLEVELS * NBEAMS,
  localparam int ADDR_W      = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NLEVELS-1:0][NBEAMS-1:0]  trig_i,
  input  logic [NBEAMS-1:0]               mask_i,
  output logic [NLEVELS-1:0][NBEAMS-1:0]  trig_o,
  input  logic                            timer_i,
  input  logic                            scal_rst_i,
  input  logic                            rd_en_i,
  input  logic [ADDR_W-1:0]               rd_addr_i,
  output logic [RD_DAT_W-1:0]             rd_dat_o,
  output logic                            rd_valid_o,
  output logic                            bank_o,
  output logic                            done_o
);

  localparam int NPAD = 2 ** ADDR_W;

  logic [NLEVELS-1:0][NBEAMS-1:0] trig_prev_q, trig_prev_d;
  logic [NLEVELS-1:0][NBEAMS-1:0] req_w;
  logic                           bank_q, bank_d;
  logic                           done_q, done_d;
  logic                           rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]              rd_addr_q, rd_addr_d;
  logic [RD_DAT_W-1:0]            rd_dat_q, rd_dat_d;
  logic                           rd_valid_q, rd_valid_d;

  // Padded to the full address space so out-of-range reads return 0
  logic [SCAL_BITS-1:0]           hold_w [NPAD];
  logic                           sat_w  [NPAD];

  // All top-level registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trig_prev_q <= '0;
      bank_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_dat_q    <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      trig_prev_q <= trig_prev_d;
      bank_q      <= bank_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_dat_q    <= rd_dat_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Rising-edge detect per channel, gated by the per-beam mask on every level
  always_comb begin
    trig_prev_d = trig_i;
    for (int l = 0; l < NLEVELS; l++) begin
      req_w[l] = trig_i[l] & ~trig_prev_q[l] & ~mask_i;
    end
  end

  // Bank toggle and done pulse; scaler clear suppresses both
  always_comb begin
    bank_d = bank_q;
    done_d = 1'b0;
    if (scal_rst_i) begin
      bank_d = 1'b0;
    end else if (timer_i) begin
      bank_d = ~bank_q;
      done_d = 1'b1;
    end
  end

  // Read pipeline: register the address, then register the muxed hold value
  always_comb begin
    rd_en_d    = rd_en_i;
    rd_addr_d  = rd_addr_i;
    rd_valid_d = rd_en_q;
    rd_dat_d   = rd_dat_q;
    if (rd_en_q) begin
      rd_dat_d     = RD_DAT_W'(hold_w[rd_addr_q]);
      rd_dat_d[31] = sat_w[rd_addr_q];
    end
  end

  assign bank_o     = bank_q;
  assign done_o     = done_q;
  assign rd_dat_o   = rd_dat_q;
  assign rd_valid_o = rd_valid_q;

  for (genvar l = 0; l < NLEVELS; l++) begin : g_level
    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
      localparam int CH = chan_addr(l, b, NBEAMS);

      trig_stretch_chan #(
        .STRETCH_LEN (STRETCH_LEN),
        .HOLDOFF_LEN (HOLDOFF_LEN),
        .SCAL_BITS   (SCAL_BITS)
      ) u_chan (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_w[l][b]),
        .timer_i    (timer_i),
        .scal_rst_i (scal_rst_i),
        .trig_o     (trig_o[l][b]),
        .hold_o     (hold_w[CH]),
        .sat_o      (sat_w[CH])
      );
    end
  end

  for (genvar i = NCHAN; i < NPAD; i++) begin : g_pad
    assign hold_w[i] = '0;
    assign sat_w[i]  = 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_trig_stretch_scaler.sv
// ============================================================================
// Module      : tb_trig_stretch_scaler
// Description : Directed bench for trig_stretch_scaler with a read-data
//               scoreboard (expected value and due cycle queued at each
//               read, popped when rd_valid_o appears). A second small
//               instance (SCAL_BITS=4) exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trig_stretch_scaler;
  import trig_stretch_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0][53:0]  trig = '0;
  logic [53:0]       mask = '0;
  logic [1:0][53:0]  trig_out;
  logic              timer = 1'b0;
  logic              scal_rst = 1'b0;
  logic              rd_en = 1'b0;
  logic [6:0]        rd_addr = '0;
  logic [31:0]       rd_dat;
  logic              rd_valid, bank, done;

  logic [0:0][1:0]   trig4 = '0;
  logic [1:0]        mask4 = '0;
  logic [0:0][1:0]   trig_out4;
  logic              timer4 = 1'b0;
  logic              rd_en4 = 1'b0;
  logic [0:0]        rd_addr4 = '0;
  logic [31:0]       rd_dat4;
  logic              rd_valid4, bank4, done4;

`ifdef TRIG_STRETCH_SATFLAG_EN
  localparam logic SAT_EXP = 1'b1;
`else
  localparam logic SAT_EXP = 1'b0;
`endif

  typedef struct {
    logic [31:0] exp;
    int          due;
    int          addr;
  } rd_exp_t;

  rd_exp_t sbq[$];
  rd_exp_t head;
  int      cyc = 0;
  int      errors = 0;
  int      checks = 0;
  logic    exp_bank = 1'b0;

  trig_stretch_scaler dut (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .mask_i(mask), .trig_o(trig_out),
    .timer_i(timer), .scal_rst_i(scal_rst), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_dat_o(rd_dat), .rd_valid_o(rd_valid), .bank_o(bank), .done_o(done)
  );

  trig_stretch_scaler #(.NBEAMS(2), .NLEVELS(1), .SCAL_BITS(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .trig_i(trig4), .mask_i(mask4), .trig_o(trig_out4),
    .timer_i(timer4), .scal_rst_i(1'b0), .rd_en_i(rd_en4), .rd_addr_i(rd_addr4),
    .rd_dat_o(rd_dat4), .rd_valid_o(rd_valid4), .bank_o(bank4), .done_o(done4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one read; its expected value is due RD_LATENCY cycles later
  task automatic rd(input int addr, input logic [31:0] exp);
    rd_en   = 1'b1;
    rd_addr = addr[6:0];
    sbq.push_back('{exp, cyc + RD_LATENCY, addr});
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
    check("sb_drain", sbq.size(), 0);
  endtask

  task automatic pulse(input int l, input int b);
    trig[l][b] = 1'b1;
    tick();
    trig[l][b] = 1'b0;
  endtask

  task automatic timer_pulse();
    timer = 1'b1;
    tick();
    timer = 1'b0;
    exp_bank = ~exp_bank;
    check("done_pulse", done, 1);
    check("bank_toggle", bank, exp_bank);
    tick();
    check("done_clear", done, 0);
  endtask

  // Scoreboard: compare each valid read against the queued expectation
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      assert (sbq.size() != 0)
      else begin
        errors++;
        $error("FAIL rd_unexpected: observed valid data %h expected no read", rd_dat);
      end
      if (sbq.size() != 0) begin
        head = sbq.pop_front();
        checks++;
        assert (rd_dat === head.exp)
        else begin
          errors++;
          $error("FAIL rd_data[%0d]: observed %h expected %h", head.addr, rd_dat, head.exp);
        end
        checks++;
        assert (cyc == head.due)
        else begin
          errors++;
          $error("FAIL rd_latency[%0d]: observed cycle %0d expected %0d", head.addr, cyc, head.due);
        end
      end
    end else if (sbq.size() != 0 && sbq[0].due < cyc) begin
      head = sbq.pop_front();
      checks++;
      assert (rd_valid === 1'b1)
      else begin
        errors++;
        $error("FAIL rd_missing[%0d]: observed valid %b expected 1", head.addr, rd_valid);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_trig_o", 32'(trig_out[0][31:0]), 0);
    check("rst_rd_dat", rd_dat, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_bank", bank, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Single pulse: stretched for exactly four cycles after acceptance
    pulse(0, 3);
    for (int k = 0; k < 4; k++) begin
      check("stretch_hi", trig_out[0][3], 1);
      tick();
    end
    check("stretch_lo", trig_out[0][3], 0);
    timer_pulse();
    rd(3, 32'd1);
    drain();

    // Pulses every 7 cycles: holdoff drops every second one
    for (int p = 0; p < 20; p++) begin
      pulse(0, 5);
      repeat (6) tick();
    end
    timer_pulse();
    rd(5, 32'd10);
    rd(3, 32'd0);
    drain();

    // Masked beam on both levels
    mask[7] = 1'b1;
    trig[0][7] = 1'b1;
    trig[1][7] = 1'b1;
    tick();
    trig[0][7] = 1'b0;
    trig[1][7] = 1'b0;
    check("mask_l0", trig_out[0][7], 0);
    check("mask_l1", trig_out[1][7], 0);
    tick();
    check("mask_l0_b", trig_out[0][7], 0);
    mask[7] = 1'b0;

    // Level held high produces a single trigger
    trig[1][9] = 1'b1;
    tick();
    check("held_first", trig_out[1][9], 1);
    repeat (20) tick();
    check("held_no_retrig", trig_out[1][9], 0);
    trig[1][9] = 1'b0;

    // Mask asserted mid-stretch does not truncate
    pulse(0, 10);
    mask[10] = 1'b1;
    check("mask_mid_1", trig_out[0][10], 1);
    repeat (3) tick();
    check("mask_mid_4", trig_out[0][10], 1);
    tick();
    check("mask_mid_end", trig_out[0][10], 0);
    mask[10] = 1'b0;

    timer_pulse();
    rd(7, 32'd0);
    rd(61, 32'd0);
    rd(63, 32'd1);
    rd(10, 32'd1);
    rd(5, 32'd0);
    drain();

    // Acceptance coincident with timer counts into the new period
    pulse(0, 3);
    repeat (13) tick();
    pulse(0, 3);
    repeat (13) tick();
    trig[0][3] = 1'b1;
    timer_pulse();
    trig[0][3] = 1'b0;
    rd(3, 32'd2);
    drain();
    repeat (14) tick();
    // Read whose mux stage coincides with timer sees the pre-update hold
    rd_en   = 1'b1;
    rd_addr = 7'd3;
    sbq.push_back('{32'd2, cyc + RD_LATENCY, 3});
    tick();
    rd_en = 1'b0;
    timer_pulse();
    rd(3, 32'd1);
    drain();

    // Scaler clear wins over timer: no done pulse, bank and holds cleared
    pulse(0, 20);
    repeat (3) tick();
    scal_rst = 1'b1;
    timer    = 1'b1;
    tick();
    scal_rst = 1'b0;
    timer    = 1'b0;
    exp_bank = 1'b0;
    check("srst_done", done, 0);
    check("srst_bank", bank, exp_bank);
    rd(20, 32'd0);
    rd(3, 32'd0);
    rd(108, 32'd0);
    rd(127, 32'd0);
    drain();
    timer_pulse();
    rd(20, 32'd0);
    drain();

    // Async reset mid-stretch
    pulse(0, 30);
    check("pre_rst_trig", trig_out[0][30], 1);
    rst = 1'b1;
    #1;
    check("async_rst_trig", trig_out[0][30], 0);
    check("async_rst_bank", bank, 0);
    exp_bank = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rd(3, 32'd0);
    drain();

    // 4-bit scaler saturates at 15
    for (int p = 0; p < 20; p++) begin
      trig4[0][0] = 1'b1;
      tick();
      trig4[0][0] = 1'b0;
      repeat (13) tick();
    end
    timer4 = 1'b1;
    tick();
    timer4 = 1'b0;
    check("sat_done", done4, 1);
    rd_en4   = 1'b1;
    rd_addr4 = 1'b0;
    tick();
    rd_addr4 = 1'b1;
    tick();
    rd_en4 = 1'b0;
    check("sat_valid", rd_valid4, 1);
    check("sat_value", rd_dat4, {SAT_EXP, 27'd0, 4'hF});
    tick();
    check("sat_other_valid", rd_valid4, 1);
    check("sat_other_value", rd_dat4, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
